// File: rtl/icache_line_responder_if.sv
// ----------------------------------------------------------------------------
// icache_line_responder_if
//
// Purpose:
//   Bundles the signals around the instruction-cache line responder:
//   - the line-read command/response bus from the cache line loader;
//   - the single-word read port toward ROM/SRAM.
//
// Signals (direction as seen from the responder, modport slave):
//   cmd_valid            in   line-read command valid
//   cmd_ready            out  command accepted when cmd_valid && cmd_ready
//   cmd_payload_address  in   byte address of any byte in the requested line
//   rsp_valid            out  response beat valid (no backpressure)
//   rsp_payload_data     out  beat data
//   rsp_payload_error    out  beat error flag
//   mem_req              out  word read request, held until mem_ack
//   mem_addr             out  word index relative to BASE
//   mem_ack              in   read complete this cycle
//   mem_rdata            in   read data, valid with mem_ack
//   mem_err              in   read error, valid with mem_ack
//
// The master modport is the mirror image and serves the environment,
// which plays both the cache and the memory.
// ----------------------------------------------------------------------------
interface icache_line_responder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_payload_address;
    logic        rsp_valid;
    logic [31:0] rsp_payload_data;
    logic        rsp_payload_error;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport slave (
        input  cmd_valid, cmd_payload_address, mem_ack, mem_rdata, mem_err,
        output cmd_ready, rsp_valid, rsp_payload_data, rsp_payload_error,
               mem_req, mem_addr
    );

    modport master (
        output cmd_valid, cmd_payload_address, mem_ack, mem_rdata, mem_err,
        input  cmd_ready, rsp_valid, rsp_payload_data, rsp_payload_error,
               mem_req, mem_addr
    );
endinterface

// File: rtl/icache_line_responder.sv
// ----------------------------------------------------------------------------
// icache_line_responder
//
// Purpose:
//   Memory-side responder for the instruction-cache line refill bus. Each
//   accepted line-read command is served as a burst of BEATS single-word
//   reads (ascending from word 0 of the line). Every returned word becomes
//   one response beat, one cycle after its mem_ack, carrying the read error
//   flag of that word. Lines outside [BASE, BASE+SIZE_BYTES) get a burst of
//   BEATS error beats (data 0), and memory is never touched.
//
// Ports:
//   clk    in   system clock, all state updates on the rising edge
//   reset  in   synchronous, active-high reset
//   bus    slave modport of icache_line_responder_if (command, response,
//          memory read port)
//
// Parameters:
//   LINE_BYTES  cache line size in bytes, power of two, >= 8
//   BASE        first byte address served, LINE_BYTES aligned
//   SIZE_BYTES  size of the served window, multiple of LINE_BYTES
// ----------------------------------------------------------------------------
module icache_line_responder #(
    parameter int unsigned LINE_BYTES = 32,
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter logic [31:0] SIZE_BYTES = 32'h0001_0000
) (
    input logic                    clk,
    input logic                    reset,
    icache_line_responder_if.slave bus
);

    localparam int unsigned        BEATS     = LINE_BYTES / 4;
    localparam int unsigned        BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [31:0]        LINE_MASK = 32'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_ERR
    } state_t;

    state_t            state_q,     state_d;
    logic [BEAT_W-1:0] beat_q,      beat_d;
    logic [29:0]       word_base_q, word_base_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;

    // Offset of the requested line from BASE. A line below BASE wraps to a
    // value of at least 2^32-BASE, which is never below SIZE_BYTES for a
    // legal window, so a single unsigned compare covers both bounds.
    logic [31:0] line_off;
    logic        in_window;

    assign line_off  = (bus.cmd_payload_address & ~LINE_MASK) - BASE;
    assign in_window = (line_off < SIZE_BYTES);

    // NOTE: sequential state only uses non-blocking assignments so every
    // flop samples the values computed in the previous cycle, independent
    // of process ordering. Reset is synchronous: it is just one more input
    // sampled on the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            word_base_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            word_base_q <= word_base_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred. The response
    // payload defaults to its own flop: it holds while rsp_valid is low.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        word_base_d = word_base_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    beat_d      = '0;
                    word_base_d = 30'(line_off >> 2);
                    state_d     = in_window ? S_READ : S_ERR;
                end
            end

            S_READ: begin
                // Wait states simply leave everything untouched, so the
                // request and its address stay stable until the ack.
                if (bus.mem_ack) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.mem_rdata;
                    rsp_err_d   = bus.mem_err;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b1;
                beat_d      = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are masked by reset so nothing is accepted or
    // requested in a reset cycle, even if the state register has not yet
    // returned to IDLE.
    assign bus.cmd_ready         = (state_q == S_IDLE) && !reset;
    assign bus.mem_req           = (state_q == S_READ) && !reset;
    assign bus.mem_addr          = word_base_q + 30'(beat_q);
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_payload_data  = rsp_data_q;
    assign bus.rsp_payload_error = rsp_err_q;

endmodule

// File: doc/icache_line_responder.md
Name: icache_line_responder

Overview:
- Memory-side responder for the instruction cache line-refill bus: answers the cache line loader's read commands with a burst of one data word per line word.
- Sits between the CPU instruction-bus command/response port and a simple single-word read port, for example on-chip ROM or SRAM in the sim SoC.
- Serialises the line read, forwards each word as a response beat and flags bus errors per beat.
- Commands outside the decoded window get an all-error burst, and memory is not touched.

Parameters:
- LINE_BYTES, 32, cache line size in bytes. Power of two, at least 8. Beats per line BEATS = LINE_BYTES/4.
- BASE, 32'h0000_0000, first byte address served. Must be LINE_BYTES aligned.
- SIZE_BYTES, 32'h0001_0000, size of the served window in bytes. Must be a multiple of LINE_BYTES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  line-read command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_payload_address  in  32  byte address of any byte in the requested line.
- rsp_valid  out  1  response beat valid. There is no backpressure: the cache always sinks beats.
- rsp_payload_data  out  32  beat data.
- rsp_payload_error  out  1  beat error flag.
- mem_req  out  1  word read request, held until mem_ack.
- mem_addr  out  30  word index relative to BASE.
- mem_ack  in  1  read complete this cycle; mem_rdata/mem_err valid when high.
- mem_rdata  in  32  read data.
- mem_err  in  1  read error.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after reset. rsp_valid=0, rsp_payload_data=0, rsp_payload_error=0, mem_req=0, mem_addr=0. State is IDLE and the beat counter is 0.
- States: IDLE, READ, ERR.
- IDLE:
  - cmd_ready=1.
  - On accept, latch line = address & ~(LINE_BYTES-1) and clear the beat counter.
  - If BASE <= line < BASE+SIZE_BYTES (unsigned compare; no overflow with legal parameters), go to READ. Otherwise go to ERR.
- READ:
  - cmd_ready=0 and mem_req=1.
  - mem_addr = ((line-BASE)>>2) + beat.
  - Each cycle with mem_ack:
    - register rsp_valid=1, rsp_payload_data=mem_rdata, rsp_payload_error=mem_err into the next cycle;
    - increment beat;
    - on the ack with beat==BEATS-1, go to IDLE.
  - mem_req stays high across wait states. mem_addr stays stable until ack.
- ERR:
  - cmd_ready=0, mem_req=0.
  - Each cycle, register a beat with data=0 and error=1, and increment beat.
  - After beat BEATS-1, go to IDLE.
- rsp_valid is 0 in every cycle that does not follow an ack or ERR cycle. rsp_payload_data and rsp_payload_error hold their last value when rsp_valid=0.
- Latency, accept in cycle T with zero-wait memory:
  - mem_req in T+1..T+BEATS.
  - Beats in T+2..T+BEATS+1.
  - cmd_ready high again from T+BEATS+1, the same cycle as the last beat.
  - A back-to-back command accepted in T+BEATS+1 gives its first beat at T+BEATS+3.
- Wait states: each cycle of mem_ack=0 delays all later beats by one cycle. No beat is dropped or duplicated.
- Beats are in ascending word order from word 0 of the line; there is no critical-word-first ordering.
- mem_err on one beat does not abort the burst. All BEATS beats are always delivered.
- cmd_valid while busy is ignored: cmd_ready=0 and the command is held by the initiator.
- Reset mid-burst:
  - Next cycle: state IDLE, rsp_valid=0, mem_req=0.
  - No remaining beats are emitted.
  - A late mem_ack from the memory side is ignored while in IDLE.
- Window top edge: the line at BASE+SIZE_BYTES-LINE_BYTES is served normally. The line at BASE+SIZE_BYTES returns an error burst.

Test Plan:
- Reset, then cmd address 0x0000_0014, LINE_BYTES=32, zero-wait memory returning word i = 0xA000_0000+i -> mem_addr 0..7 in T+1..T+8; 8 beats 0xA000_0000..0xA000_0007 in T+2..T+9; error=0; cmd_ready=1 at T+9.
- Same command with memory inserting 2 wait cycles before word 3 -> beat 3 at T+7; last beat at T+11; exactly 8 beats in order; mem_addr holds 3 during the waits.
- mem_err=1 on word 5 only -> beat 5 has error=1, all other beats error=0; 8 beats delivered.
- cmd address 0x0001_0000 with SIZE_BYTES=0x10000 -> mem_req never asserted; 8 beats of data 0, error=1 in T+2..T+9. Address 0x0000_FFE0 -> normal burst with mem_addr 0x3FF8..0x3FFF.
- Two commands back to back, second held valid from T+1 -> second accepted at T+9; its first beat at T+11; no gap or overlap in mem_addr sequencing.
- Reset asserted for one cycle at T+4 mid-burst -> rsp_valid=0 from T+5; no further beats; cmd_ready=1 in the cycle after reset deasserts; a new command then completes normally.
